// File: rtl/jelly_img_pkg.sv
// Shared img-bus definitions: scheduler state encoding and the flag bundle
// that travels alongside every img-bus beat.
package jelly_img_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_HFLUSH = 2'd2;
  localparam logic [1:0] ST_VFLUSH = 2'd3;

  typedef struct packed {
    logic line_first;
    logic line_last;
    logic pixel_first;
    logic pixel_last;
    logic de;
  } img_flags_t;

endpackage

// File: rtl/jelly_img_flush_counter.sv
// Loadable down-counter used to time flush runs. After a load of N it
// takes N decrements to drain; 'last' is high while the count is 1, i.e.
// during the final cycle of the run.
module jelly_img_flush_counter #(
  parameter int WIDTH = 12
) (
  input  logic             reset,
  input  logic             clk,
  input  logic             cke,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             last
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load wins over decrement; saturate at zero.
  always_comb begin
    // NOTE: assigning a default first means every path writes count_d, so no latch is inferred.
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register, frozen while cke is low.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state flops use non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      count_q <= '0;
    end else if (cke) begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == WIDTH'(1));

endmodule

// File: rtl/jelly_img_line_flush_scheduler.sv
// AXI4-Stream video to img-bus converter. Frames start on tuser; each line is
// followed by h_flush cycles of valid/!de and each frame by v_flush blank
// lines so the downstream pixel and line buffers drain their borders.
module jelly_img_line_flush_scheduler
  import jelly_img_pkg::*;
#(
  parameter int USER_WIDTH = 0,
  parameter int DATA_WIDTH = 8,
  parameter int X_WIDTH    = 12,
  parameter int Y_WIDTH    = 12,
  parameter int USER_BITS  = (USER_WIDTH > 0 ? USER_WIDTH : 1)
) (
  input  logic                  reset,
  input  logic                  clk,
  input  logic                  cke,

  input  logic [X_WIDTH-1:0]    param_width,
  input  logic [Y_WIDTH-1:0]    param_height,
  input  logic [X_WIDTH-1:0]    param_h_flush,
  input  logic [Y_WIDTH-1:0]    param_v_flush,

  output logic                  busy,
  output logic                  err_tlast,

  input  logic                  s_axi4s_tuser,
  input  logic                  s_axi4s_tlast,
  input  logic [USER_BITS-1:0]  s_axi4s_tuser_ext,
  input  logic [DATA_WIDTH-1:0] s_axi4s_tdata,
  input  logic                  s_axi4s_tvalid,
  output logic                  s_axi4s_tready,

  output logic                  m_img_line_first,
  output logic                  m_img_line_last,
  output logic                  m_img_pixel_first,
  output logic                  m_img_pixel_last,
  output logic                  m_img_de,
  output logic [USER_BITS-1:0]  m_img_user,
  output logic [DATA_WIDTH-1:0] m_img_data,
  output logic                  m_img_valid
);

  logic [1:0]            state_q, state_d;
  logic [X_WIDTH-1:0]    x_q, x_d;
  logic [Y_WIDTH-1:0]    y_q, y_d;
  logic                  vtail_q, vtail_d;
  logic [X_WIDTH-1:0]    width_m1_q, width_m1_d;
  logic [Y_WIDTH-1:0]    height_m1_q, height_m1_d;
  logic [X_WIDTH-1:0]    h_flush_q, h_flush_d;
  logic [Y_WIDTH-1:0]    v_flush_q, v_flush_d;

  img_flags_t            flags_q, flags_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [USER_BITS-1:0]  user_q, user_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  logic                  h_load, h_dec, h_last;
  logic                  v_load, v_dec, v_last;
  logic                  line_done, vline_done;

  // In IDLE the first beat is framed with the live parameters; afterwards
  // only the shadow copies are used.
  logic                  idle;
  logic [X_WIDTH-1:0]    cur_width_m1, cur_h_flush, x_cur;
  logic [Y_WIDTH-1:0]    cur_height_m1, cur_v_flush, y_cur;
  logic                  x_end, y_end;

  assign idle          = (state_q == ST_IDLE);
  assign cur_width_m1  = idle ? (param_width - X_WIDTH'(1))  : width_m1_q;
  assign cur_height_m1 = idle ? (param_height - Y_WIDTH'(1)) : height_m1_q;
  assign cur_h_flush   = idle ? param_h_flush : h_flush_q;
  assign cur_v_flush   = idle ? param_v_flush : v_flush_q;
  assign x_cur         = idle ? '0 : x_q;
  assign y_cur         = idle ? '0 : y_q;
  assign x_end         = (x_cur == cur_width_m1);
  assign y_end         = (y_cur == cur_height_m1);

  // Input is only taken in the pixel states and never while held in reset.
  assign s_axi4s_tready = cke & ~reset & ((state_q == ST_IDLE) | (state_q == ST_ACTIVE));

  jelly_img_flush_counter #(.WIDTH(X_WIDTH)) u_h_counter (
    .reset      (reset),
    .clk        (clk),
    .cke        (cke),
    .load       (h_load),
    .load_value (cur_h_flush),
    .dec        (h_dec),
    .last       (h_last)
  );

  jelly_img_flush_counter #(.WIDTH(Y_WIDTH)) u_v_counter (
    .reset      (reset),
    .clk        (clk),
    .cke        (cke),
    .load       (v_load),
    .load_value (cur_v_flush),
    .dec        (v_dec),
    .last       (v_last)
  );

  // Scheduler: decides the next output beat and advances the x/y counters.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    vtail_d     = vtail_q;
    width_m1_d  = width_m1_q;
    height_m1_d = height_m1_q;
    h_flush_d   = h_flush_q;
    v_flush_d   = v_flush_q;
    flags_d     = flags_q;
    valid_d     = valid_q;
    data_d      = data_q;
    user_d      = user_q;
    err_d       = err_q;
    h_load      = 1'b0;
    h_dec       = 1'b0;
    v_load      = 1'b0;
    v_dec       = 1'b0;
    line_done   = 1'b0;
    vline_done  = 1'b0;

    if (cke) begin
      valid_d = 1'b0;
      flags_d = '0;
      err_d   = 1'b0;

      case (state_q)
        ST_IDLE, ST_ACTIVE: begin
          // In IDLE only a frame-start beat is used; others are dropped.
          if (s_axi4s_tvalid && (!idle || s_axi4s_tuser)) begin
            if (idle) begin
              width_m1_d  = cur_width_m1;
              height_m1_d = cur_height_m1;
              h_flush_d   = param_h_flush;
              v_flush_d   = param_v_flush;
            end
            valid_d             = 1'b1;
            flags_d.de          = 1'b1;
            flags_d.pixel_first = (x_cur == '0);
            flags_d.pixel_last  = x_end;
            flags_d.line_first  = (y_cur == '0);
            flags_d.line_last   = y_end;
            data_d              = s_axi4s_tdata;
            user_d              = s_axi4s_tuser_ext;
            err_d               = (s_axi4s_tlast != x_end);
            state_d             = ST_ACTIVE;
            x_d                 = x_cur + X_WIDTH'(1);
            y_d                 = y_cur;
            if (x_end) begin
              x_d = '0;
              if (cur_h_flush != '0) begin
                state_d = ST_HFLUSH;
                h_load  = 1'b1;
              end else begin
                line_done = 1'b1;
              end
            end
          end
        end

        ST_HFLUSH: begin
          valid_d = 1'b1;
          h_dec   = 1'b1;
          if (h_last) begin
            line_done = 1'b1;
          end
        end

        default: begin
          // Blank line: width cycles with pixel markers, then an h_flush tail.
          valid_d = 1'b1;
          if (!vtail_q) begin
            flags_d.pixel_first = (x_q == '0);
            flags_d.pixel_last  = x_end;
            x_d                 = x_q + X_WIDTH'(1);
            if (x_end) begin
              x_d = '0;
              if (h_flush_q != '0) begin
                vtail_d = 1'b1;
                h_load  = 1'b1;
              end else begin
                vline_done = 1'b1;
              end
            end
          end else begin
            h_dec = 1'b1;
            if (h_last) begin
              vtail_d    = 1'b0;
              vline_done = 1'b1;
            end
          end
          if (vline_done) begin
            if (v_last) begin
              state_d = ST_IDLE;
            end else begin
              v_dec = 1'b1;
            end
          end
        end
      endcase

      // End of an active line (after its horizontal flush, if any).
      if (line_done) begin
        if (!y_end) begin
          state_d = ST_ACTIVE;
          y_d     = y_cur + Y_WIDTH'(1);
        end else begin
          y_d = '0;
          if (cur_v_flush != '0) begin
            state_d = ST_VFLUSH;
            v_load  = 1'b1;
            vtail_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    end

    // Busy covers the cycle that shows the final beat of the frame.
    busy_d = cke ? ((state_d != ST_IDLE) || (state_q != ST_IDLE)) : busy_q;
  end

  // State, counters, shadow parameters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      vtail_q     <= 1'b0;
      width_m1_q  <= '0;
      height_m1_q <= '0;
      h_flush_q   <= '0;
      v_flush_q   <= '0;
      flags_q     <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      user_q      <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      vtail_q     <= vtail_d;
      width_m1_q  <= width_m1_d;
      height_m1_q <= height_m1_d;
      h_flush_q   <= h_flush_d;
      v_flush_q   <= v_flush_d;
      flags_q     <= flags_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      user_q      <= user_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign busy              = busy_q;
  assign err_tlast         = err_q;
  assign m_img_line_first  = flags_q.line_first;
  assign m_img_line_last   = flags_q.line_last;
  assign m_img_pixel_first = flags_q.pixel_first;
  assign m_img_pixel_last  = flags_q.pixel_last;
  assign m_img_de          = flags_q.de;
  assign m_img_user        = user_q;
  assign m_img_data        = data_q;
  assign m_img_valid       = valid_q;

endmodule

// File: tb/tb_jelly_img_line_flush_scheduler.sv
// Directed bench for the line/frame flush scheduler: a scenario table run
// against a hand-written expected img-bus stream, plus hand sequences for
// dropped pre-frame beats, mid-frame parameter change and async reset.
module tb_jelly_img_line_flush_scheduler;

  localparam int XW = 12;
  localparam int YW = 12;

  logic          reset;
  logic          clk = 1'b0;
  logic          cke;
  logic [XW-1:0] param_width, param_h_flush;
  logic [YW-1:0] param_height, param_v_flush;
  logic          busy, err_tlast;
  logic          s_tuser, s_tlast, s_tvalid, s_tready;
  logic [0:0]    s_user;
  logic [7:0]    s_data;
  logic          m_lf, m_ll, m_pf, m_pl, m_de, m_valid;
  logic [0:0]    m_user;
  logic [7:0]    m_data;

  jelly_img_line_flush_scheduler #(
    .USER_WIDTH (0),
    .DATA_WIDTH (8),
    .X_WIDTH    (XW),
    .Y_WIDTH    (YW)
  ) dut (
    .reset             (reset),
    .clk               (clk),
    .cke               (cke),
    .param_width       (param_width),
    .param_height      (param_height),
    .param_h_flush     (param_h_flush),
    .param_v_flush     (param_v_flush),
    .busy              (busy),
    .err_tlast         (err_tlast),
    .s_axi4s_tuser     (s_tuser),
    .s_axi4s_tlast     (s_tlast),
    .s_axi4s_tuser_ext (s_user),
    .s_axi4s_tdata     (s_data),
    .s_axi4s_tvalid    (s_tvalid),
    .s_axi4s_tready    (s_tready),
    .m_img_line_first  (m_lf),
    .m_img_line_last   (m_ll),
    .m_img_pixel_first (m_pf),
    .m_img_pixel_last  (m_pl),
    .m_img_de          (m_de),
    .m_img_user        (m_user),
    .m_img_data        (m_data),
    .m_img_valid       (m_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       de;
    logic       pf;
    logic       pl;
    logic       lf;
    logic       ll;
    logic [7:0] data;
  } row_t;

  typedef struct {
    int width;
    int height;
    int hflush;
    int vflush;
    bit gaps;
    bit cke_tog;
    int bad;
    int mid;
    int rows;
    int errs;
  } scen_t;

  row_t  exp_rows[18];
  scen_t scen[5];
  row_t  got[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Per-cycle log of a frame, index 0 = first cycle with busy high.
  logic cyc_busy[64];
  logic cyc_ready[64];
  int   n_cyc;
  int   err_pulses;
  int   gate_viol;

  // Frame driver configuration.
  int cfg_width, cfg_nbeats, cfg_bad, cfg_mid, cfg_chg_beat, cfg_chg_width, cfg_abort;
  bit cfg_gaps, cfg_cke_tog;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drives one frame of beats (data = beat index) and records the img-bus
  // stream from every edge taken with cke=1 that produced valid.
  task automatic run_frame();
    int b = 0;
    int guard = 0;
    bit started = 1'b0;
    bit last_cke = 1'b0;
    bit tog = 1'b0;
    got.delete();
    n_cyc = 0;
    err_pulses = 0;
    forever begin
      @(negedge clk);
      if (last_cke) begin
        if (busy) started = 1'b1;
        if (m_valid) got.push_back(row_t'{m_de, m_pf, m_pl, m_lf, m_ll, m_data});
        if (err_tlast) err_pulses++;
      end
      if (started && n_cyc < 64) begin
        cyc_busy[n_cyc]  = busy;
        cyc_ready[n_cyc] = s_tready;
        n_cyc++;
      end
      if (cfg_abort >= 0 && n_cyc == cfg_abort + 1) return;
      if (started && !busy && b >= cfg_nbeats) break;
      guard++;
      if (guard > 2000) begin
        check("frame_timeout", 1, 0);
        break;
      end
      tog = ~tog;
      cke = cfg_cke_tog ? tog : 1'b1;
      if (b == cfg_chg_beat) param_width = XW'(cfg_chg_width);
      s_tvalid = (b < cfg_nbeats) && (!cfg_gaps || $urandom_range(0, 2) != 0);
      s_tuser  = (b == 0) || (b == cfg_mid);
      s_tlast  = ((b % cfg_width) == cfg_width - 1) || (b == cfg_bad);
      s_data   = 8'(b);
      s_user   = 1'(b);
      #1;
      if (!cke && s_tready) gate_viol++;
      if (cke && s_tready && s_tvalid) b++;
      last_cke = cke;
    end
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    cke      = 1'b1;
  endtask

  task automatic set_default_cfg();
    cfg_width = 4; cfg_nbeats = 8; cfg_bad = -1; cfg_mid = -1;
    cfg_chg_beat = -1; cfg_chg_width = 4; cfg_abort = -1;
    cfg_gaps = 1'b0; cfg_cke_tog = 1'b0;
  endtask

  int busy_n;
  int seen;

  initial begin
    // Expected stream for width=4, height=2, h_flush=2, v_flush=1
    // (the first 12 rows are the whole frame when v_flush=0).
    exp_rows[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    exp_rows[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    exp_rows[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
    exp_rows[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3};
    exp_rows[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3};
    exp_rows[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3};
    exp_rows[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd4};
    exp_rows[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5};
    exp_rows[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd6};
    exp_rows[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd7};
    exp_rows[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd7};
    exp_rows[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd7};
    exp_rows[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd7};
    exp_rows[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd7};
    exp_rows[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd7};
    exp_rows[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd7};
    exp_rows[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd7};
    exp_rows[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd7};

    //          w  h  hf vf gaps tog bad mid rows errs
    scen[0] = '{4, 2, 2, 0, 1'b0, 1'b0, -1, -1, 12, 0};
    scen[1] = '{4, 2, 2, 1, 1'b0, 1'b0, -1, -1, 18, 0};
    scen[2] = '{4, 2, 2, 0, 1'b0, 1'b0,  2,  5, 12, 1};
    scen[3] = '{4, 2, 2, 1, 1'b1, 1'b1, -1, -1, 18, 0};
    scen[4] = '{4, 2, 2, 0, 1'b1, 1'b0, -1, -1, 12, 0};

    reset = 1'b1; cke = 1'b1;
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; s_data = '0; s_user = '0;
    param_width = 4; param_height = 2; param_h_flush = 2; param_v_flush = 0;
    gate_viol = 0;
    set_default_cfg();

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_valid", m_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_tready", s_tready, 0);
    check("reset_flags", {m_lf, m_ll, m_pf, m_pl, m_de, err_tlast}, 0);
    reset = 1'b0;

    // Beats without tuser in IDLE are consumed and dropped.
    seen = 0;
    s_tvalid = 1'b1; s_tuser = 1'b0; s_data = 8'hAA;
    #1;
    check("idle_tready", s_tready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (m_valid || busy) seen++;
    end
    s_tvalid = 1'b0;
    check("drop_pre_tuser", seen, 0);

    // Scenario table.
    for (int s = 0; s < 5; s++) begin
      set_default_cfg();
      param_width   = XW'(scen[s].width);
      param_height  = YW'(scen[s].height);
      param_h_flush = XW'(scen[s].hflush);
      param_v_flush = YW'(scen[s].vflush);
      cfg_width   = scen[s].width;
      cfg_nbeats  = scen[s].width * scen[s].height;
      cfg_gaps    = scen[s].gaps;
      cfg_cke_tog = scen[s].cke_tog;
      cfg_bad     = scen[s].bad;
      cfg_mid     = scen[s].mid;
      run_frame();
      check($sformatf("s%0d_rows", s), got.size(), scen[s].rows);
      for (int i = 0; i < scen[s].rows; i++)
        check($sformatf("s%0d_row%0d", s, i), (i < got.size()) ? got[i] : row_t'('1), exp_rows[i]);
      check($sformatf("s%0d_err_pulses", s), err_pulses, scen[s].errs);
      if (!scen[s].gaps && !scen[s].cke_tog) begin
        busy_n = 0;
        for (int i = 0; i < n_cyc; i++) if (cyc_busy[i]) busy_n++;
        check($sformatf("s%0d_busy_cycles", s), busy_n, scen[s].rows);
        check($sformatf("s%0d_ready_c0", s), cyc_ready[0], 1);
        check($sformatf("s%0d_ready_hflush3", s), cyc_ready[3], 0);
        check($sformatf("s%0d_ready_hflush4", s), cyc_ready[4], 0);
        check($sformatf("s%0d_ready_c5", s), cyc_ready[5], 1);
        if (scen[s].vflush != 0) check($sformatf("s%0d_ready_vflush", s), cyc_ready[14], 0);
      end
    end
    check("tready_cke_gate", gate_viol, 0);

    // Width change mid-frame applies only to the next frame.
    set_default_cfg();
    param_width = 4; param_v_flush = 0;
    cfg_chg_beat = 2; cfg_chg_width = 8;
    run_frame();
    check("chg_f1_rows", got.size(), 12);
    for (int i = 0; i < 12; i++)
      check($sformatf("chg_f1_row%0d", i), (i < got.size()) ? got[i] : row_t'('1), exp_rows[i]);
    set_default_cfg();
    cfg_width = 8; cfg_nbeats = 16;
    run_frame();
    check("chg_f2_rows", got.size(), 20);
    if (got.size() == 20) begin
      check("chg_f2_pf0", {got[0].de, got[0].pf}, 2'b11);
      check("chg_f2_pl7", {got[7].de, got[7].pl, got[7].data}, {2'b11, 8'd7});
      check("chg_f2_flush8", {got[8].de, got[9].de}, 2'b00);
      check("chg_f2_pf10", {got[10].de, got[10].pf, got[10].ll}, 3'b111);
      check("chg_f2_pl17", {got[17].pl, got[17].data}, {1'b1, 8'd15});
    end
    param_width = 4;

    // Asynchronous reset during the horizontal flush of the last line.
    set_default_cfg();
    cfg_abort = 10;
    run_frame();
    check("pre_reset_busy", busy, 1);
    #1 reset = 1'b1;
    #1;
    check("async_reset_valid", m_valid, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_tready", s_tready, 0);
    check("async_reset_out", {m_lf, m_ll, m_pf, m_pl, m_de, m_data}, 0);
    @(negedge clk);
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    reset = 1'b0;
    set_default_cfg();
    run_frame();
    check("post_reset_rows", got.size(), 12);
    for (int i = 0; i < 12; i++)
      check($sformatf("post_reset_row%0d", i), (i < got.size()) ? got[i] : row_t'('1), exp_rows[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jelly_img_line_flush_scheduler.md
Name: jelly_img_line_flush_scheduler

Overview:
- Converts an AXI4-Stream video input (tuser = frame start, tlast = end of line) into the img-bus frame format used by the window/pixel-buffer chain.
- After every line it inserts a programmable number of horizontal flush cycles (valid=1, de=0), so the horizontal pixel buffer can push out its right-border pixels.
- After every frame it inserts programmable vertical flush lines, so downstream line buffers drain.
- Sits directly in front of the pixel-buffer / line-buffer pipeline.

Parameters:
- USER_WIDTH, 0, width of sideband user data (0 = none)
- DATA_WIDTH, 8, pixel data width
- X_WIDTH, 12, width of horizontal counters and parameters
- Y_WIDTH, 12, width of vertical counters and parameters
- USER_BITS, (USER_WIDTH>0 ? USER_WIDTH : 1), physical user width

Ports:
- reset  in  1  asynchronous, active-high reset
- clk  in  1  clock
- cke  in  1  clock enable for the whole block
- param_width  in  X_WIDTH  active pixels per line (>=1)
- param_height  in  Y_WIDTH  active lines per frame (>=1)
- param_h_flush  in  X_WIDTH  flush cycles after each line (0 allowed)
- param_v_flush  in  Y_WIDTH  flush lines after each frame (0 allowed)
- busy  out  1  high from frame acceptance until the last flush cycle has been emitted
- err_tlast  out  1  one-cycle pulse when the input tlast disagrees with the internal column counter
- s_axi4s_tuser  in  1  frame start
- s_axi4s_tlast  in  1  end of line
- s_axi4s_tuser_ext  in  USER_BITS  sideband data passed to m_img_user
- s_axi4s_tdata  in  DATA_WIDTH  pixel
- s_axi4s_tvalid  in  1  input valid
- s_axi4s_tready  out  1  input ready
- m_img_line_first, m_img_line_last, m_img_pixel_first, m_img_pixel_last, m_img_de  out  1 each  img-bus flags
- m_img_user  out  USER_BITS  user data
- m_img_data  out  DATA_WIDTH  pixel data
- m_img_valid  out  1  img-bus valid

Behaviour:
- Reset (asynchronous): state=IDLE; all counters 0; all m_img_* outputs 0; busy=0; err_tlast=0; s_axi4s_tready=0. Reset asserted mid-frame aborts immediately; no trailing flush is emitted.
- cke=0: state, counters and outputs hold; s_axi4s_tready=0.
- All outputs are registered. Latency is 1 cycle from an accepted input beat (tvalid & tready & cke) to m_img_valid.
- Parameters are latched into shadow registers when a frame starts (tuser accepted in IDLE). Changes during a frame take effect at the next frame.
- States:
  - IDLE: tready=cke. Beats with tuser=0 are discarded and produce no output. A beat with tuser=1 latches the parameters, resets x=0 and y=0, is emitted as the first pixel, and moves the block to ACTIVE (or HFLUSH if width=1). busy rises on this edge.
  - ACTIVE: tready=cke. Each accepted beat emits valid=1, de=1, with:
    - pixel_first = (x==0)
    - pixel_last = (x==width-1)
    - line_first = (y==0)
    - line_last = (y==height-1)
    - data and user passed through
    Cycles with no beat emit valid=0. When x==width-1 is emitted: x=0, then go to HFLUSH if h_flush>0; otherwise go to ACTIVE with y+1, or to VFLUSH/IDLE after the last line.
  - tuser=1 seen in ACTIVE is ignored and the beat is treated as data.
  - err_tlast pulses for 1 cycle when an accepted beat has tlast != (x==width-1). Framing always follows the counters, never tlast.
  - HFLUSH: tready=0. Emits h_flush consecutive cycles of valid=1, de=0; all first/last flags 0; data and user hold their last values. Exit rule: not the last line -> ACTIVE with y+1; last line -> VFLUSH if v_flush>0, else IDLE.
  - VFLUSH: tready=0. Emits v_flush lines, each of (width + h_flush) cycles with valid=1 and de=0. pixel_first is asserted on the first cycle of each flush line and pixel_last on cycle width-1; line_first and line_last stay 0. After the last cycle: IDLE, busy falls.
- Counter comparisons use the latched width-1 / height-1 at full counter width. No wrap is needed because counters reset at their terminal values.
- The earliest next frame starts on the cycle after returning to IDLE.

Decomposition:
- Shared package jelly_img_pkg holds:
  - state encoding constants: ST_IDLE=0, ST_ACTIVE=1, ST_HFLUSH=2, ST_VFLUSH=3
  - the img-bus flag bundle typedef (line_first, line_last, pixel_first, pixel_last, de)
- One natural sub-module: jelly_img_flush_counter, a loadable down-counter with a terminal flag. It is instantiated twice, for the h_flush and v_flush counts.

Test Plan:
- width=4, height=2, h_flush=2, v_flush=0, continuous tvalid -> output sequence de=1,1,1,1,0,0,1,1,1,1,0,0. pixel_first at cycles 0 and 6; line_last on the second line; busy high for 12 cycles.
- Same frame with v_flush=1 -> 6 extra cycles with de=0; pixel_first on the 1st and pixel_last on the 4th of those cycles; line flags 0; busy falls after cycle 18.
- Beats before tuser are dropped and no m_img_valid appears; tuser mid-frame keeps counters unchanged; tlast on x=2 with width=4 -> err_tlast pulses once and framing is unaffected.
- cke toggled 0/1 every other cycle, and random tvalid gaps -> output identical to the reference run once cycles with valid=0 and cke=0 are removed; tready=0 whenever cke=0 or in either FLUSH state.
- param_width changed from 4 to 8 mid-frame -> current frame keeps 4-pixel lines; the next frame uses 8.
- reset asserted during HFLUSH of line 1 -> all outputs 0 immediately (asynchronously); after release, a frame with tuser=1 starts cleanly at x=0, y=0.
